// File: rtl/fifo_pkg.sv
// Shared defaults and mode constants for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE     = 32;
  localparam int unsigned DEF_ADDR_SIZE     = 8;
  localparam int unsigned DEF_AEMPTY_THRESH = 4;
  localparam int unsigned DEF_AFULL_MARGIN  = 4;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned def_afull_thresh(input int unsigned addr_size);
    return (32'd1 << addr_size) - DEF_AFULL_MARGIN;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Write/read handshake, status and error bundle of sync_fifo_ctl.
interface sync_fifo_ctl_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) ();

  logic [DATA_SIZE-1:0] w_data;
  logic                 w_en;
  logic                 w_full;
  logic                 w_almost_full;
  logic                 r_en;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_empty;
  logic                 r_almost_empty;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;

  modport master (
    output w_data, w_en, r_en, clr_err,
    input  w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_data, w_en, r_en, clr_err,
    output w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// with read-old-data behaviour on an address collision.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy, thresholds, optional
// first-word-fall-through output and sticky error flags around fifo_mem.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE     = DEF_ADDR_SIZE,
  parameter int unsigned FWFT          = MODE_STD,
  parameter int unsigned AFULL_THRESH  = def_afull_thresh(ADDR_SIZE),
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_ctl_if.slave fifo
);

  localparam int unsigned        DEPTH    = 1 << ADDR_SIZE;
  localparam bit                 IS_FWFT  = (FWFT == MODE_FWFT);
  localparam logic [ADDR_SIZE:0] ONE_C    = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_thresh_chk
    $error("sync_fifo_ctl: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADDR_SIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic                 afull_q, afull_d, aempty_q, aempty_d;
  logic                 rd_pend_q, valid_q, valid_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic [DATA_SIZE-1:0] ram_dout;
  logic [ADDR_SIZE-1:0] ram_raddr;
  logic                 ram_re, empty_out, wr_ok, rd_ok;

  always_comb begin
    empty_out = IS_FWFT ? !valid_q : empty_q;
    rd_ok     = fifo.r_en && !empty_out;
    wr_ok     = fifo.w_en && (!full_q || rd_ok);

    wptr_d = wr_ok ? wptr_q + ONE_C : wptr_q;
    rptr_d = rd_ok ? rptr_q + ONE_C : rptr_q;

    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + ONE_C;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - ONE_C;
    end

    empty_d  = (wptr_d == rptr_d);
    full_d   = (wptr_d[ADDR_SIZE] != rptr_d[ADDR_SIZE]) &&
               (wptr_d[ADDR_SIZE-1:0] == rptr_d[ADDR_SIZE-1:0]);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    // FWFT: the RAM output register is the head register; it always tracks
    // mem[next rptr], but only once that slot was written on an earlier edge.
    // Standard: the RAM is read on the accepting edge (old data on a full
    // pass-through) and the word is moved to r_data one edge later.
    valid_d   = IS_FWFT ? (rptr_d != wptr_q) : rd_pend_q;
    ram_re    = IS_FWFT ? valid_d : rd_ok;
    ram_raddr = IS_FWFT ? rptr_d[ADDR_SIZE-1:0] : rptr_q[ADDR_SIZE-1:0];
    rdata_d   = rd_pend_q ? ram_dout : rdata_q;

    ovf_d = ovf_q;
    if (fifo.w_en && full_q && !rd_ok) begin
      ovf_d = 1'b1;
    end else if (fifo.clr_err) begin
      ovf_d = 1'b0;
    end

    udf_d = udf_q;
    if (fifo.r_en && empty_out) begin
      udf_d = 1'b1;
    end else if (fifo.clr_err) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      rd_pend_q <= rd_ok;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[ADDR_SIZE-1:0]),
    .wdata_i (fifo.w_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_dout)
  );

  assign fifo.w_full         = full_q;
  assign fifo.w_almost_full  = afull_q;
  assign fifo.r_data         = IS_FWFT ? ram_dout : rdata_q;
  assign fifo.r_valid        = valid_q;
  assign fifo.r_empty        = empty_out;
  assign fifo.r_almost_empty = aempty_q;
  assign fifo.count          = count_q;
  assign fifo.overflow       = ovf_q;
  assign fifo.underflow      = udf_q;

endmodule
